// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multi-cycle 16-bit teaching CPU: opcodes,
// FSM states and instruction field layout.
package cpu_mc_pkg;

  localparam int INST_W = 15;
  localparam int DATA_W = 16;
  localparam int REG_N  = 8;

  localparam int OP_MSB  = 14;
  localparam int OP_LSB  = 11;
  localparam int RA_MSB  = 10;
  localparam int RA_LSB  = 8;
  localparam int RB_MSB  = 7;
  localparam int RB_LSB  = 5;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_MOV = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_SL  = 4'h5,
    OP_SR  = 4'h6,
    OP_SRA = 4'h7,
    OP_LDL = 4'h8,
    OP_LDH = 4'h9,
    OP_CMP = 4'hA,
    OP_JE  = 4'hB,
    OP_JMP = 4'hC,
    OP_LD  = 4'hD,
    OP_ST  = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_mc_seg7.sv
// Hex nibble to 7-segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
module cpu_mc_seg7 (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle 16-bit CPU with req/ack instruction and data memories and halt/resume.
// Optional display shadows and decoders are enabled with CPU_MC_SEG7_EN.
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int         PC_W     = 8,
  parameter int         SEG_N    = 6,
  parameter logic [7:0] SEG_BASE = 8'hF0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [7:0]        dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              run,
  output logic              halted,
  output logic [PC_W-1:0]   pc
`ifdef CPU_MC_SEG7_EN
  ,
  output logic [7*SEG_N-1:0] o_seg7
`endif
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                flag_eq_q, flag_eq_d;
  logic [DATA_W-1:0]   regs_q [REG_N];
  logic [DATA_W-1:0]   regs_d [REG_N];
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;
  logic [7:0]          dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;

  opcode_e             op;
  logic [2:0]          ra, rb;
  logic [7:0]          imm;
  logic [DATA_W-1:0]   ra_val, rb_val;
  logic [PC_W-1:0]     pc_inc, jmp_target;

  assign op         = opcode_e'(inst_q[OP_MSB:OP_LSB]);
  assign ra         = inst_q[RA_MSB:RA_LSB];
  assign rb         = inst_q[RB_MSB:RB_LSB];
  assign imm        = inst_q[IMM_MSB:IMM_LSB];
  assign ra_val     = regs_q[ra];
  assign rb_val     = regs_q[rb];
  assign pc_inc     = pc_q + PC_W'(1);
  assign jmp_target = PC_W'(imm);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    flag_eq_d    = flag_eq_q;
    regs_d       = regs_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;

    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_MOV: regs_d[ra] = rb_val;
          OP_ADD: regs_d[ra] = ra_val + rb_val;
          OP_SUB: regs_d[ra] = ra_val - rb_val;
          OP_AND: regs_d[ra] = ra_val & rb_val;
          OP_OR:  regs_d[ra] = ra_val | rb_val;
          OP_SL:  regs_d[ra] = ra_val << 1;
          OP_SR:  regs_d[ra] = ra_val >> 1;
          OP_SRA: regs_d[ra] = {ra_val[DATA_W-1], ra_val[DATA_W-1:1]};
          OP_LDL: regs_d[ra] = {ra_val[15:8], imm};
          OP_LDH: regs_d[ra] = {imm, ra_val[7:0]};
          OP_CMP: flag_eq_d = (ra_val == rb_val);
          OP_JE:  if (flag_eq_q) pc_d = jmp_target;
          OP_JMP: pc_d = jmp_target;
          OP_LD, OP_ST: begin
            // Address/data are registered here so they stay stable until ack.
            state_d      = MEM;
            pc_d         = pc_q;
            dmem_req_d   = 1'b1;
            dmem_we_d    = (op == OP_ST);
            dmem_addr_d  = imm;
            dmem_wdata_d = ra_val;
          end
          OP_HLT: begin
            state_d = HALT;
            pc_d    = pc_q;
          end
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (!dmem_we_q) regs_d[ra] = dmem_rdata;
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      HALT: begin
        if (run) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      pc_q         <= '0;
      inst_q       <= '0;
      flag_eq_q    <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      flag_eq_q    <= flag_eq_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      for (int i = 0; i < REG_N; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Fetch request is held off while reset is asserted even though state is FETCH.
  assign imem_req   = (state_q == FETCH) && reset;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign halted     = (state_q == HALT);
  assign pc         = pc_q;

`ifdef CPU_MC_SEG7_EN
  logic [3:0] digit_q [SEG_N];
  logic [3:0] digit_d [SEG_N];

  always_comb begin
    digit_d = digit_q;
    if (state_q == MEM && dmem_ack && dmem_we_q) begin
      for (int k = 0; k < SEG_N; k++) begin
        if (dmem_addr_q == SEG_BASE + 8'(k)) digit_d[k] = dmem_wdata_q[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SEG_N; k++) digit_q[k] <= '0;
    end else begin
      for (int k = 0; k < SEG_N; k++) digit_q[k] <= digit_d[k];
    end
  end

  for (genvar k = 0; k < SEG_N; k++) begin : g_seg
    cpu_mc_seg7 u_seg7 (
      .hex (digit_q[k]),
      .seg (o_seg7[7*k +: 7])
    );
  end
`endif

endmodule
